// File: rtl/skullfet_pkg.sv
// Shared definitions for the skullfet pad loopback checker: FSM states,
// pattern-mode encoding and the Galois LFSR used for pseudo-random stimulus.
package skullfet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Pattern-mode encoding on mode_i
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_LFSR   = 1'b1;

  // One step of the Galois LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/skullfet_sync.sv
// N-flop synchronizer with asynchronous reset for pad-return signals.
module skullfet_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/skullfet_loopback_checker.sv
// Drives the skullfet inverter input pad, samples its output pad back through
// a synchronizer after a programmable settle time, and tallies pass/fail.
module skullfet_loopback_checker
  import skullfet_pkg::*;
#(
  parameter int          CNT_W       = 16,
  parameter int          SETTLE_W    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          INVERT      = 1,
  parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                mode_i,
  input  logic [CNT_W-1:0]    num_vec_i,
  input  logic [SETTLE_W-1:0] settle_i,
  output logic                stim_o,
  input  logic                resp_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    pass_cnt_o,
  output logic [CNT_W-1:0]    fail_cnt_o,
  output logic [CNT_W-1:0]    first_fail_o,
  output logic                fail_seen_o
);

  // The settle window must cover the synchronizer latency plus one cycle
  localparam logic [SETTLE_W-1:0] SETTLE_MIN = SETTLE_W'(SYNC_STAGES + 1);

  state_t              state_q, state_nxt;
  logic                resp_sync;
  logic                accept_start, drive_en, settle_en, sample_en;
  logic                mode_q;
  logic [CNT_W-1:0]    num_vec_q, vec_idx_q;
  logic [SETTLE_W-1:0] settle_eff, settle_eff_q, settle_cnt_q;
  logic [15:0]         lfsr_q, lfsr_nxt;
  logic                stim_q;
  logic                expected_bit, match, last_vec;

  skullfet_sync #(
    .STAGES (SYNC_STAGES)
  ) u_resp_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (resp_i),
    .q   (resp_sync)
  );

  assign settle_eff   = (settle_i < SETTLE_MIN) ? SETTLE_MIN : settle_i;
  assign lfsr_nxt     = lfsr_step(lfsr_q);
  assign expected_bit = (INVERT != 0) ? ~stim_q : stim_q;
  assign match        = (resp_sync == expected_bit);
  assign last_vec     = ((vec_idx_q + CNT_W'(1)) == num_vec_q);

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and per-cycle strobes; abort overrides everything
  always_comb begin
    state_nxt    = state_q;
    accept_start = 1'b0;
    drive_en     = 1'b0;
    settle_en    = 1'b0;
    sample_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          accept_start = 1'b1;
          state_nxt    = (num_vec_i == '0) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        drive_en  = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_en = 1'b1;
        if (settle_cnt_q == SETTLE_W'(1)) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        state_nxt = last_vec ? ST_DONE : ST_DRIVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_i) begin
      state_nxt    = ST_IDLE;
      accept_start = 1'b0;
      drive_en     = 1'b0;
      settle_en    = 1'b0;
      sample_en    = 1'b0;
    end
  end

  // Registered status flags follow the state being entered
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SETTLE) ||
                (state_nxt == ST_SAMPLE);
      done_o <= (state_nxt == ST_DONE);
    end
  end

  // Run configuration is captured only when a start is accepted
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mode_q       <= MODE_TOGGLE;
      num_vec_q    <= '0;
      settle_eff_q <= '0;
    end else if (accept_start) begin
      mode_q       <= mode_i;
      num_vec_q    <= num_vec_i;
      settle_eff_q <= settle_eff;
    end
  end

  // Stimulus generation: toggle or LFSR bit, updated once per vector
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stim_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else if (accept_start) begin
      lfsr_q <= LFSR_SEED;
    end else if (drive_en) begin
      if (mode_q == MODE_TOGGLE) begin
        stim_q <= ~stim_q;
      end else begin
        lfsr_q <= lfsr_nxt;
        stim_q <= lfsr_nxt[0];
      end
    end
  end

  // Settle countdown, loaded as the stimulus edge happens
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      settle_cnt_q <= '0;
    end else if (drive_en) begin
      settle_cnt_q <= settle_eff_q;
    end else if (settle_en) begin
      settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
    end
  end

  // Result tally: saturating counters, first-failure capture, vector index
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pass_cnt_o   <= '0;
      fail_cnt_o   <= '0;
      first_fail_o <= '0;
      fail_seen_o  <= 1'b0;
      vec_idx_q    <= '0;
    end else if (accept_start) begin
      pass_cnt_o   <= '0;
      fail_cnt_o   <= '0;
      first_fail_o <= '0;
      fail_seen_o  <= 1'b0;
      vec_idx_q    <= '0;
    end else if (sample_en) begin
      if (match) begin
        if (pass_cnt_o != '1) begin
          pass_cnt_o <= pass_cnt_o + CNT_W'(1);
        end
      end else begin
        if (fail_cnt_o != '1) begin
          fail_cnt_o <= fail_cnt_o + CNT_W'(1);
        end
        if (!fail_seen_o) begin
          first_fail_o <= vec_idx_q;
          fail_seen_o  <= 1'b1;
        end
      end
      vec_idx_q <= vec_idx_q + CNT_W'(1);
    end
  end

  assign stim_o = stim_q;

endmodule

// File: tb/tb_skullfet_loopback_checker.sv
// Directed bench for skullfet_loopback_checker with a modelled pad inverter.
module tb_skullfet_loopback_checker;

  localparam int CNT_W    = 16;
  localparam int SETTLE_W = 8;

  logic                wb_clk_i    = 1'b0;
  logic                wb_rst_i    = 1'b1;
  logic                start_i     = 1'b0;
  logic                abort_i     = 1'b0;
  logic                mode_i      = 1'b0;
  logic [CNT_W-1:0]    num_vec_i   = '0;
  logic [SETTLE_W-1:0] settle_i    = '0;
  logic                resp_stuck0 = 1'b0;
  logic                stim_o, resp_i, busy_o, done_o, fail_seen_o;
  logic [CNT_W-1:0]    pass_cnt_o, fail_cnt_o, first_fail_o;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] ref_lfsr;

  // Pad model: ideal inverter, or output stuck at 0
  assign resp_i = resp_stuck0 ? 1'b0 : ~stim_o;

  always #5 wb_clk_i = ~wb_clk_i;

  skullfet_loopback_checker dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .mode_i       (mode_i),
    .num_vec_i    (num_vec_i),
    .settle_i     (settle_i),
    .stim_o       (stim_o),
    .resp_i       (resp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_cnt_o   (pass_cnt_o),
    .fail_cnt_o   (fail_cnt_o),
    .first_fail_o (first_fail_o),
    .fail_seen_o  (fail_seen_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_run(input logic mode, input int nv, input int st);
    mode_i    = mode;
    num_vec_i = CNT_W'(nv);
    settle_i  = SETTLE_W'(st);
    start_i   = 1'b1;
    tick(1);
    start_i   = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_stim", 32'(stim_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_pass", 32'(pass_cnt_o), 0);
    check("rst_fail", 32'(fail_cnt_o), 0);
    check("rst_first", 32'(first_fail_o), 0);
    check("rst_seen", 32'(fail_seen_o), 0);
    wb_rst_i = 1'b0;
    tick(2);

    // Ideal inverter, toggle, 8 vectors, settle 4: 6 cycles per vector
    start_run(1'b0, 8, 4);
    check("t1_busy_start", 32'(busy_o), 1);
    check("t1_done_start", 32'(done_o), 0);
    tick(47);
    check("t1_done_early", 32'(done_o), 0);
    check("t1_busy_late", 32'(busy_o), 1);
    tick(1);
    check("t1_done", 32'(done_o), 1);
    check("t1_busy_end", 32'(busy_o), 0);
    check("t1_pass", 32'(pass_cnt_o), 8);
    check("t1_fail", 32'(fail_cnt_o), 0);
    check("t1_seen", 32'(fail_seen_o), 0);
    check("t1_first", 32'(first_fail_o), 0);
    check("t1_stim_end", 32'(stim_o), 0);
    tick(3);
    check("t1_done_hold", 32'(done_o), 1);

    // Stuck-at-0 pad: odd-index vectors drive 0 and expect 1
    resp_stuck0 = 1'b1;
    start_run(1'b0, 6, 4);
    tick(36);
    check("t2_done", 32'(done_o), 1);
    check("t2_pass", 32'(pass_cnt_o), 3);
    check("t2_fail", 32'(fail_cnt_o), 3);
    check("t2_first", 32'(first_fail_o), 1);
    check("t2_seen", 32'(fail_seen_o), 1);
    resp_stuck0 = 1'b0;

    // LFSR mode, settle clamped to 3: 5 cycles per vector
    ref_lfsr = 16'hACE1;
    start_run(1'b1, 100, 0);
    check("t3_seen_clear", 32'(fail_seen_o), 0);
    for (int v = 0; v < 100; v++) begin
      ref_lfsr = {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
      tick(1);
      check($sformatf("t3_stim%0d", v), 32'(stim_o), 32'(ref_lfsr[0]));
      tick(4);
    end
    check("t3_done", 32'(done_o), 1);
    check("t3_pass", 32'(pass_cnt_o), 100);
    check("t3_fail", 32'(fail_cnt_o), 0);

    // Zero vectors: straight to DONE with cleared counts
    start_run(1'b0, 0, 4);
    check("t4_done", 32'(done_o), 1);
    check("t4_busy", 32'(busy_o), 0);
    check("t4_pass", 32'(pass_cnt_o), 0);
    check("t4_fail", 32'(fail_cnt_o), 0);
    tick(2);
    check("t4_done_hold", 32'(done_o), 1);
    check("t4_busy_hold", 32'(busy_o), 0);

    // Abort during vector 3 of 10 with a simultaneous start
    start_run(1'b0, 10, 4);
    tick(19);
    abort_i = 1'b1;
    start_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("t5_busy", 32'(busy_o), 0);
    check("t5_done", 32'(done_o), 0);
    check("t5_pass", 32'(pass_cnt_o), 3);
    check("t5_fail", 32'(fail_cnt_o), 0);
    tick(8);
    check("t5_busy_idle", 32'(busy_o), 0);
    check("t5_done_idle", 32'(done_o), 0);
    check("t5_pass_hold", 32'(pass_cnt_o), 3);

    // Asynchronous reset in the middle of SETTLE
    start_run(1'b0, 4, 4);
    tick(8);
    check("t6_busy_pre", 32'(busy_o), 1);
    check("t6_pass_pre", 32'(pass_cnt_o), 1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_pass", 32'(pass_cnt_o), 0);
    check("t6_rst_stim", 32'(stim_o), 0);
    check("t6_rst_done", 32'(done_o), 0);
    #1 wb_rst_i = 1'b0;
    tick(2);
    start_run(1'b0, 2, 3);
    tick(9);
    check("t6_done_early", 32'(done_o), 0);
    tick(1);
    check("t6_done", 32'(done_o), 1);
    check("t6_pass", 32'(pass_cnt_o), 2);
    check("t6_fail", 32'(fail_cnt_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
